// File: rtl/mem_access_unit.sv
// LC-3 memory access unit: holds MAR/MDR, decodes the four keyboard/display device
// registers locally and reaches external memory over a req/ack port, returning R.
module mem_access_unit #(
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    output logic        ready,
    output logic [15:0] mar_q,
    output logic [15:0] mdr_q,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ack,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic [15:0] r_rdata_hold;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_kb_full;
    logic [7:0]  r_kbdr;
    logic        r_dsr_ready;
    logic [7:0]  r_disp_data;
    logic        r_disp_valid;

    logic        w_in_idle;
    logic        w_in_done;
    logic        w_mem_done;
    logic        w_is_kbsr;
    logic        w_is_kbdr;
    logic        w_is_dsr;
    logic        w_is_ddr;
    logic        w_dev_hit;
    logic        w_start;
    logic        w_dev_read;
    logic        w_kbdr_read;
    logic        w_ddr_write;
    logic        w_mem_launch;
    logic [15:0] w_dev_rdata;

    // Address decode always looks at the held MAR, never at the bus.
    assign w_is_kbsr    = (r_mar == KBSR_ADDR);
    assign w_is_kbdr    = (r_mar == KBDR_ADDR);
    assign w_is_dsr     = (r_mar == DSR_ADDR);
    assign w_is_ddr     = (r_mar == DDR_ADDR);
    assign w_dev_hit    = w_is_kbsr | w_is_kbdr | w_is_dsr | w_is_ddr;

    assign w_start      = w_in_idle & mio_en;
    assign w_dev_read   = w_start & w_dev_hit & ~r_w;
    assign w_kbdr_read  = w_dev_read & w_is_kbdr;
    assign w_ddr_write  = w_start & w_is_ddr & r_w;
    assign w_mem_launch = w_start & ~w_dev_hit;

    always_comb begin
        w_dev_rdata = 16'h0000;
        if (w_is_kbsr) begin
            w_dev_rdata = {r_kb_full, 15'b0};
        end else if (w_is_kbdr) begin
            w_dev_rdata = {8'h00, r_kbdr};
        end else if (w_is_dsr) begin
            w_dev_rdata = {r_dsr_ready, 15'b0};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: state register / next state / state-decoded outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mio_en) begin
                    w_next_state = w_dev_hit ? ST_DONE : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_idle  = 1'b0;
        w_in_done  = 1'b0;
        w_mem_done = 1'b0;
        case (r_state)
            ST_IDLE:     w_in_idle  = 1'b1;
            ST_MEM_WAIT: w_mem_done = mem_ack;
            ST_DONE:     w_in_done  = 1'b1;
            default:     w_in_idle  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // MAR / MDR
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mar <= 16'h0000;
            r_mdr <= 16'h0000;
        end else begin
            if (w_in_idle && ld_mar) begin
                r_mar <= bus_in;
            end
            if (w_in_idle && ld_mdr && !mio_en) begin
                r_mdr <= bus_in;
            end else if (w_in_done && ld_mdr && !r_w) begin
                r_mdr <= r_rdata_hold;
            end
        end
    end

    // ------------------------------------------------------------------
    // External memory port.
    // Handshake: mem_req rises at the launch edge together with mem_addr,
    // mem_we and mem_wdata; all four stay frozen until mem_ack is sampled
    // high, and that same edge completes the transfer and drops the request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
        end else if (w_mem_launch) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= r_w;
            r_mem_addr  <= r_mar;
            r_mem_wdata <= r_mdr;
        end else if (w_mem_done) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata_hold <= 16'h0000;
        end else if (w_dev_read) begin
            r_rdata_hold <= w_dev_rdata;
        end else if (w_mem_done) begin
            r_rdata_hold <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Keyboard: a fresh character outranks the clear caused by a KBDR read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kb_full <= 1'b0;
            r_kbdr    <= 8'h00;
        end else if (kb_valid) begin
            r_kb_full <= 1'b1;
            r_kbdr    <= kb_data;
        end else if (w_kbdr_read) begin
            r_kb_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display: a DDR write outranks a simultaneous disp_ack
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dsr_ready  <= 1'b1;
            r_disp_data  <= 8'h00;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            if (w_ddr_write) begin
                r_dsr_ready  <= 1'b0;
                r_disp_data  <= r_mdr[7:0];
                r_disp_valid <= 1'b1;
            end else if (disp_ack) begin
                r_dsr_ready  <= 1'b1;
            end
        end
    end

    assign ready       = w_in_done;
    assign mar_q       = r_mar;
    assign mdr_q       = r_mdr;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign disp_data   = r_disp_data;
    assign disp_valid  = r_disp_valid;
    assign o_dbg_state = r_state;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer end of the address path. Holds MAR/MDR, takes the effective address the datapath drives on the bus, and performs the memory or device access requested by the control FSM.
- Returns the LC-3 R (ready) signal to the control FSM.
- Decodes the four LC-3 device registers (KBSR/KBDR/DSR/DDR) locally. Every other address goes to external memory through a req/ack handshake.

Parameters:
- KBSR_ADDR, 16'hFE00, keyboard status address
- KBDR_ADDR, 16'hFE02, keyboard data address
- DSR_ADDR, 16'hFE04, display status address
- DDR_ADDR, 16'hFE06, display data address

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- bus_in  in  16  datapath bus
- ld_mar  in  1  load MAR from bus_in
- ld_mdr  in  1  load MDR (source chosen by mio_en)
- mio_en  in  1  start/hold a memory or device access
- r_w  in  1  0 = read, 1 = write
- ready  out  1  R: access complete, high exactly one cycle
- mar_q  out  16  MAR contents
- mdr_q  out  16  MDR contents
- mem_req  out  1  external memory request
- mem_we  out  1  external write enable
- mem_addr  out  16  external address
- mem_wdata  out  16  external write data
- mem_rdata  in  16  external read data, valid with mem_ack
- mem_ack  in  1  external completion
- kb_data  in  8  keyboard character
- kb_valid  in  1  one-cycle pulse, new character
- disp_data  out  8  display character
- disp_valid  out  1  one-cycle pulse, character issued
- disp_ack  in  1  display consumed character

Behaviour:
- Reset (rst_n=0 at edge):
  - State IDLE.
  - mar_q, mdr_q, mem_addr, mem_wdata, disp_data = 0.
  - mem_req, mem_we, ready, disp_valid = 0.
  - KBSR[15] = 0, KBDR = 0, DSR[15] = 1.
  - Reset mid-access aborts it: mem_req drops next edge, and any ack arriving later is ignored.
- MAR/MDR:
  - In IDLE, ld_mar loads mar_q from bus_in.
  - In IDLE, ld_mdr with mio_en=0 loads mdr_q from bus_in.
  - ld_mar and ld_mdr are ignored outside IDLE.
- FSM states: IDLE, MEM_WAIT, DONE.
- IDLE with mio_en=1, device address (mar_q equals one of the four parameters):
  - The device access executes at this edge. Next state is DONE, so latency is 1 cycle.
  - Device read: selected value captured into rdata_hold. KBSR reads {KBSR[15],15'b0}. KBDR reads {8'b0,KBDR}. DSR reads {DSR[15],15'b0}. DDR reads 0.
  - Reading KBDR clears KBSR[15].
  - Device write to DDR: disp_data <= mdr_q[7:0], disp_valid = 1 for one cycle, DSR[15] <= 0.
  - Writes to KBSR/KBDR/DSR are ignored.
- IDLE with mio_en=1, any other address:
  - Registered at this edge: mem_req=1, mem_addr=mar_q, mem_we=r_w, mem_wdata=mdr_q. Next state MEM_WAIT.
- MEM_WAIT:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high.
  - On mem_ack: rdata_hold <= mem_rdata, mem_req <= 0, mem_we <= 0, next state DONE.
  - No timeout; the unit waits indefinitely.
- DONE:
  - ready = 1, decoded combinationally from the state.
  - If r_w=0 and ld_mdr=1: mdr_q <= rdata_hold at the edge leaving DONE.
  - Next state is IDLE unconditionally. A new access starts only when mio_en is sampled in IDLE.
  - The control FSM must drop mio_en on the cycle after it sees ready.
- Minimum latency: mio_en sampled at edge 0, mem_ack present in the first MEM_WAIT cycle, ready in cycle 2. Device accesses give ready in cycle 1.
- Keyboard:
  - kb_valid: KBDR <= kb_data, KBSR[15] <= 1.
  - kb_valid in the same cycle as a KBDR read: the new character wins and KBSR[15] stays 1.
- Display:
  - disp_ack sets DSR[15] <= 1.
  - disp_ack in the same cycle as a DDR write: the write wins and DSR[15] = 0.
- r_w and mar_q are sampled at access start; later changes are ignored until DONE.

Test Plan:
- Reset: hold rst_n=0 two cycles -> all outputs 0, DSR read later returns 16'h8000.
- Memory read: MAR=16'h3000, mem_ack after 3 wait cycles with rdata 16'h1234, ld_mdr=1 -> mem_req high exactly 4 cycles, addr 3000, we=0; ready one cycle; mdr_q=16'h1234 the next cycle.
- Memory write: MAR=16'h4001, MDR=16'hBEEF, r_w=1, ack in the first MEM_WAIT cycle -> mem_we=1, wdata BEEF, ready exactly 2 cycles after start, mdr_q unchanged.
- Keyboard: kb_valid with 8'h41, then read KBSR -> 16'h8000. Read KBDR -> 16'h0041 and KBSR[15]=0. Second KBSR read -> 0. kb_valid coincident with the KBDR read -> KBSR stays 1.
- Display: write 16'h0058 to DDR -> disp_data=8'h58, disp_valid one cycle, DSR reads 0; after disp_ack, DSR reads 16'h8000; no mem_req during any of this.
- Reset mid-access: rst_n=0 during MEM_WAIT -> next edge mem_req=0 and state IDLE; a late mem_ack produces no ready and no MDR change.
